// File: rtl/instr_issue_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module  : instr_issue_queue_pkg
// Purpose : Shared types and defaults for the instruction issue queue.
//           - reg_addr_t      : architectural register index
//           - fetch_entry_t   : raw fetch payload (pc + instruction word)
//           - decoded_instr_t : decoded fields used by the grouping rules
//           - reads_reg()     : true if an entry reads a nonzero register
// Revision: 1.0 - initial release
// ============================================================================
package instr_issue_queue_pkg;

    localparam int C_FETCH_NUM = 2;
    localparam int C_ISSUE_NUM = 2;
    localparam int C_DEPTH     = 8;

    typedef logic [4:0] reg_addr_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    typedef struct packed {
        reg_addr_t rs1;
        reg_addr_t rs2;
        reg_addr_t rd;
        logic      is_load;
        logic      is_mem;
        logic      is_controlflow;
    } decoded_instr_t;

    // Register 0 is hardwired, so it never creates a dependency.
    function automatic logic reads_reg(input decoded_instr_t d, input reg_addr_t r);
        return (r != '0) && ((d.rs1 == r) || (d.rs2 == r));
    endfunction

endpackage
`default_nettype wire

// File: rtl/instr_issue_queue_group_check.sv
`default_nettype none
// ============================================================================
// Module  : instr_issue_queue_group_check
// Purpose : Combinational issue-group selector. Given the window at the queue
//           head, returns the longest issuable in-order prefix.
// Ports   : i_stall       - downstream hold, forces an empty group
//           i_win_valid   - window lane exists
//           i_win_dec     - decoded fields per window lane (lane 0 oldest)
//           i_ex_is_load  - EX lane holds a load
//           i_ex_rd       - EX lane destination register
//           o_issue_num   - number of lanes issued
// Revision: 1.0 - initial release
// ============================================================================
module instr_issue_queue_group_check
    import instr_issue_queue_pkg::*;
#(
    parameter int ISSUE_NUM = C_ISSUE_NUM
) (
    input  logic                               i_stall,
    input  logic [ISSUE_NUM-1:0]               i_win_valid,
    input  decoded_instr_t [ISSUE_NUM-1:0]     i_win_dec,
    input  logic [ISSUE_NUM-1:0]               i_ex_is_load,
    input  reg_addr_t [ISSUE_NUM-1:0]          i_ex_rd,
    output logic [$clog2(ISSUE_NUM+1)-1:0]     o_issue_num
);

    localparam int C_NW = $clog2(ISSUE_NUM + 1);

    logic [ISSUE_NUM-1:0] w_lane_ok;
    int                   w_len;
    logic                 w_blocked;
    logic                 w_unused_dec;

    // is_load and the youngest lane's rd do not influence grouping.
    assign w_unused_dec = ^i_win_dec;

    // Per-lane hazard screen against EX loads and older lanes of the group.
    always_comb begin
        w_lane_ok = '0;
        for (int k = 0; k < ISSUE_NUM; k++) begin
            w_lane_ok[k] = i_win_valid[k] && !i_stall;
            for (int j = 0; j < ISSUE_NUM; j++) begin
                if (i_ex_is_load[j] && reads_reg(i_win_dec[k], i_ex_rd[j])) begin
                    w_lane_ok[k] = 1'b0;
                end
            end
            for (int j = 0; j < k; j++) begin
                if (reads_reg(i_win_dec[k], i_win_dec[j].rd)) begin
                    w_lane_ok[k] = 1'b0;
                end
                if (i_win_dec[k].is_mem && i_win_dec[j].is_mem) begin
                    w_lane_ok[k] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        w_len     = 0;
        w_blocked = 1'b0;
        for (int k = 0; k < ISSUE_NUM; k++) begin
            if (!w_blocked && w_lane_ok[k]) begin
                w_len = k + 1;
            end else begin
                w_blocked = 1'b1;
            end
        end
        // A branch must leave together with its delay slot. Dropping a
        // trailing branch can leave another branch last, so walk downward.
        for (int k = ISSUE_NUM - 1; k >= 0; k--) begin
            if ((w_len == k + 1) && i_win_dec[k].is_controlflow) begin
                w_len = k;
            end
        end
    end

    assign o_issue_num = C_NW'(w_len);

endmodule
`default_nettype wire

// File: rtl/instr_issue_queue.sv
`default_nettype none
// ============================================================================
// Module  : instr_issue_queue
// Purpose : DEPTH-entry circular instruction buffer between fetch and execute
//           with in-order multi-issue from the head.
// Ports   : clk, rst_n        - clock, asynchronous active-low reset
//           i_flush           - discard all queued entries (wins over push)
//           i_stall           - issue nothing this cycle
//           i_fetch_valid/entry/decoded - up to FETCH_NUM pushes, lane order
//           o_fetch_ready     - at least FETCH_NUM free slots
//           i_ex_is_load/i_ex_rd - EX stage load tracking for load-use
//           o_issue_entry/decoded/valid/num - issued group, lane 0 oldest
//           o_occupancy       - registered entry count
// Config  : ISSUE_QUEUE_BYPASS_EN - when the queue is empty the window is
//           taken straight from the fetch lanes and only the remainder is
//           stored. Undefined: one-cycle minimum entry-to-issue latency.
// Revision: 1.0 - initial release
// ============================================================================
module instr_issue_queue
    import instr_issue_queue_pkg::*;
#(
    parameter int FETCH_NUM = C_FETCH_NUM,
    parameter int ISSUE_NUM = C_ISSUE_NUM,
    parameter int DEPTH     = C_DEPTH
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              i_flush,
    input  logic                              i_stall,
    input  logic [FETCH_NUM-1:0]              i_fetch_valid,
    input  fetch_entry_t [FETCH_NUM-1:0]      i_fetch_entry,
    input  decoded_instr_t [FETCH_NUM-1:0]    i_fetch_decoded,
    output logic                              o_fetch_ready,
    input  logic [ISSUE_NUM-1:0]              i_ex_is_load,
    input  reg_addr_t [ISSUE_NUM-1:0]         i_ex_rd,
    output fetch_entry_t [ISSUE_NUM-1:0]      o_issue_entry,
    output decoded_instr_t [ISSUE_NUM-1:0]    o_issue_decoded,
    output logic [ISSUE_NUM-1:0]              o_issue_valid,
    output logic [$clog2(ISSUE_NUM+1)-1:0]    o_issue_num,
    output logic [$clog2(DEPTH+1)-1:0]        o_occupancy
);

    localparam int C_AW = $clog2(DEPTH);
    localparam int C_CW = $clog2(DEPTH + 1);
    localparam int C_NW = $clog2(ISSUE_NUM + 1);

    fetch_entry_t   r_entry [DEPTH];
    decoded_instr_t r_dec   [DEPTH];
    logic [C_AW-1:0] r_head;
    logic [C_AW-1:0] r_tail;
    logic [C_CW-1:0] r_count;

    logic                           w_bypass;
    logic                           w_do_push;
    logic [ISSUE_NUM-1:0]           w_win_valid;
    fetch_entry_t [ISSUE_NUM-1:0]   w_win_entry;
    decoded_instr_t [ISSUE_NUM-1:0] w_win_dec;
    logic [C_NW-1:0]                w_issue_num;
    logic [C_NW-1:0]                w_skip;
    logic [C_CW-1:0]                w_fetch_cnt;
    logic [C_CW-1:0]                w_push_cnt;
    logic [C_CW-1:0]                w_pop;

    assign o_fetch_ready = (r_count <= C_CW'(DEPTH - FETCH_NUM));
    assign w_do_push     = o_fetch_ready && !i_flush;

`ifdef ISSUE_QUEUE_BYPASS_EN
    assign w_bypass = (r_count == '0) && o_fetch_ready;
`else
    assign w_bypass = 1'b0;
`endif

    // Issue window: lane k maps to head + k, or to fetch lane k on bypass.
    generate
        for (genvar k = 0; k < ISSUE_NUM; k++) begin : g_win
            logic [C_AW-1:0] w_slot;
            assign w_slot = r_head + C_AW'(k);
            if (k < FETCH_NUM) begin : g_fetch_lane
                assign w_win_valid[k] = w_bypass ? i_fetch_valid[k]   : (r_count > C_CW'(k));
                assign w_win_entry[k] = w_bypass ? i_fetch_entry[k]   : r_entry[w_slot];
                assign w_win_dec[k]   = w_bypass ? i_fetch_decoded[k] : r_dec[w_slot];
            end else begin : g_queue_lane
                assign w_win_valid[k] = !w_bypass && (r_count > C_CW'(k));
                assign w_win_entry[k] = r_entry[w_slot];
                assign w_win_dec[k]   = r_dec[w_slot];
            end
            assign o_issue_valid[k] = (w_issue_num > C_NW'(k));
        end
    endgenerate

    instr_issue_queue_group_check #(
        .ISSUE_NUM (ISSUE_NUM)
    ) u_group_check (
        .i_stall      (i_stall),
        .i_win_valid  (w_win_valid),
        .i_win_dec    (w_win_dec),
        .i_ex_is_load (i_ex_is_load),
        .i_ex_rd      (i_ex_rd),
        .o_issue_num  (w_issue_num)
    );

    assign o_issue_num     = w_issue_num;
    assign o_issue_entry   = w_win_entry;
    assign o_issue_decoded = w_win_dec;
    assign o_occupancy     = r_count;

    always_comb begin
        w_fetch_cnt = '0;
        for (int i = 0; i < FETCH_NUM; i++) begin
            w_fetch_cnt = w_fetch_cnt + C_CW'(i_fetch_valid[i]);
        end
    end

    // On bypass the issued fetch lanes are consumed directly and never stored.
    assign w_skip     = w_bypass ? w_issue_num : '0;
    assign w_push_cnt = w_do_push ? (w_fetch_cnt - C_CW'(w_skip)) : '0;
    assign w_pop      = w_bypass ? '0 : C_CW'(w_issue_num);

    // Payload storage needs no reset: occupancy alone qualifies it.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            for (int i = 0; i < FETCH_NUM; i++) begin
                if (i_fetch_valid[i] && (i >= int'(w_skip))) begin
                    r_entry[r_tail + C_AW'(i - int'(w_skip))] <= i_fetch_entry[i];
                    r_dec[r_tail + C_AW'(i - int'(w_skip))]   <= i_fetch_decoded[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + C_AW'(w_pop);
            r_tail  <= r_tail + C_AW'(w_push_cnt);
            r_count <= r_count + w_push_cnt - w_pop;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_issue_queue.sv
`default_nettype none
// ============================================================================
// Module  : tb_instr_issue_queue
// Purpose : Self-checking bench for instr_issue_queue (default build).
//           Directed scenarios with literal expectations, then randomized
//           traffic compared every cycle against a queue-based model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_instr_issue_queue;
    import instr_issue_queue_pkg::*;

    logic                  clk;
    logic                  rst_n;
    logic                  i_flush;
    logic                  i_stall;
    logic [1:0]            i_fetch_valid;
    fetch_entry_t [1:0]    i_fetch_entry;
    decoded_instr_t [1:0]  i_fetch_decoded;
    logic                  o_fetch_ready;
    logic [1:0]            i_ex_is_load;
    reg_addr_t [1:0]       i_ex_rd;
    fetch_entry_t [1:0]    o_issue_entry;
    decoded_instr_t [1:0]  o_issue_decoded;
    logic [1:0]            o_issue_valid;
    logic [1:0]            o_issue_num;
    logic [3:0]            o_occupancy;

    instr_issue_queue #(
        .FETCH_NUM (2),
        .ISSUE_NUM (2),
        .DEPTH     (8)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_flush         (i_flush),
        .i_stall         (i_stall),
        .i_fetch_valid   (i_fetch_valid),
        .i_fetch_entry   (i_fetch_entry),
        .i_fetch_decoded (i_fetch_decoded),
        .o_fetch_ready   (o_fetch_ready),
        .i_ex_is_load    (i_ex_is_load),
        .i_ex_rd         (i_ex_rd),
        .o_issue_entry   (o_issue_entry),
        .o_issue_decoded (o_issue_decoded),
        .o_issue_valid   (o_issue_valid),
        .o_issue_num     (o_issue_num),
        .o_occupancy     (o_occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int pc_ctr  = 0;

    typedef struct packed {
        fetch_entry_t   e;
        decoded_instr_t d;
    } item_t;

    item_t mq[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected group size straight from the rules: grow the group lane by
    // lane until a hazard, then shed any trailing branch without its slot.
    function automatic int model_num();
        int  n;
        bit  mem_seen;
        bit  haz;
        if (i_stall) return 0;
        n        = 0;
        mem_seen = 1'b0;
        for (int k = 0; k < 2 && k < mq.size(); k++) begin
            decoded_instr_t d;
            d   = mq[k].d;
            haz = 1'b0;
            for (int j = 0; j < 2; j++) begin
                if (i_ex_is_load[j] && i_ex_rd[j] != 0 &&
                    (d.rs1 == i_ex_rd[j] || d.rs2 == i_ex_rd[j])) haz = 1'b1;
            end
            for (int j = 0; j < k; j++) begin
                if (mq[j].d.rd != 0 && (d.rs1 == mq[j].d.rd || d.rs2 == mq[j].d.rd)) haz = 1'b1;
            end
            if (d.is_mem && mem_seen) haz = 1'b1;
            if (haz) break;
            mem_seen = mem_seen | d.is_mem;
            n++;
        end
        while (n > 0 && mq[n-1].d.is_controlflow) n--;
        return n;
    endfunction

    always @(negedge rst_n) mq.delete();

    // Model compare: every cycle out of reset.
    always @(negedge clk) begin
        int en;
        bit er;
        if (rst_n) begin
            er = ((8 - mq.size()) >= 2);
            en = model_num();
            chk("m_fetch_ready", 64'(o_fetch_ready), 64'(er));
            chk("m_occupancy", 64'(o_occupancy), 64'(mq.size()));
            chk("m_issue_num", 64'(o_issue_num), 64'(en));
            chk("m_issue_valid", 64'(o_issue_valid), 64'((1 << en) - 1));
            for (int k = 0; k < en; k++) begin
                chk("m_issue_entry", o_issue_entry[k], mq[k].e);
                chk("m_issue_decoded", 64'(o_issue_decoded[k]), 64'(mq[k].d));
            end
            if (i_flush) begin
                mq.delete();
            end else begin
                for (int k = 0; k < en; k++) void'(mq.pop_front());
                if (er) begin
                    for (int l = 0; l < 2; l++) begin
                        if (i_fetch_valid[l]) mq.push_back('{e: i_fetch_entry[l], d: i_fetch_decoded[l]});
                    end
                end
            end
        end
    end

    function automatic decoded_instr_t mk(input int rd, input int rs1, input int rs2,
                                          input bit ld, input bit mem, input bit cf);
        decoded_instr_t d;
        d.rd             = reg_addr_t'(rd);
        d.rs1            = reg_addr_t'(rs1);
        d.rs2            = reg_addr_t'(rs2);
        d.is_load        = ld;
        d.is_mem         = mem;
        d.is_controlflow = cf;
        return d;
    endfunction

    task automatic set_in(input int nv, input decoded_instr_t d0, input decoded_instr_t d1,
                          input logic st, input logic fl);
        @(posedge clk);
        #1;
        i_stall      = st;
        i_flush      = fl;
        i_ex_is_load = '0;
        i_ex_rd      = '0;
        for (int l = 0; l < 2; l++) begin
            i_fetch_valid[l]       = (l < nv);
            i_fetch_entry[l].pc    = 32'(pc_ctr);
            i_fetch_entry[l].instr = $urandom();
            pc_ctr += 4;
        end
        i_fetch_decoded[0] = d0;
        i_fetch_decoded[1] = d1;
    endtask

    task automatic expect_at(input string tag, input int num, input int occ);
        @(negedge clk);
        chk({tag, "_issue_num"}, 64'(o_issue_num), 64'(num));
        chk({tag, "_occupancy"}, 64'(o_occupancy), 64'(occ));
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_occ"}, 64'(o_occupancy), 64'd0);
        chk({tag, "_valid"}, 64'(o_issue_valid), 64'd0);
        chk({tag, "_num"}, 64'(o_issue_num), 64'd0);
        chk({tag, "_ready"}, 64'(o_fetch_ready), 64'd1);
    endtask

    decoded_instr_t c_nop;
    int             pc_a;
    int             nv;

    initial begin
        c_nop           = mk(0, 0, 0, 0, 0, 0);
        rst_n           = 1'b1;
        i_flush         = 1'b0;
        i_stall         = 1'b0;
        i_fetch_valid   = '0;
        i_fetch_entry   = '0;
        i_fetch_decoded = '0;
        i_ex_is_load    = '0;
        i_ex_rd         = '0;
        #1 rst_n = 1'b0;
        #2 chk_reset("por");
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Independent ALU pairs.
        pc_a = pc_ctr;
        set_in(2, mk(1, 2, 3, 0, 0, 0), mk(4, 5, 6, 0, 0, 0), 0, 0);
        expect_at("alu0", 0, 0);
        set_in(2, mk(7, 2, 3, 0, 0, 0), mk(8, 5, 6, 0, 0, 0), 0, 0);
        expect_at("alu1", 2, 2);
        chk("alu1_pc0", 64'(o_issue_entry[0].pc), 64'(pc_a));
        chk("alu1_pc1", 64'(o_issue_entry[1].pc), 64'(pc_a + 4));
        set_in(0, c_nop, c_nop, 0, 0);
        expect_at("alu2", 2, 2);
        set_in(0, c_nop, c_nop, 0, 0);
        expect_at("alu3", 0, 0);

        // Load-use: head reads $3 while EX holds a load into $3.
        set_in(2, mk(2, 3, 0, 1, 1, 0), mk(6, 3, 0, 0, 0, 0), 1, 0);
        expect_at("lu0", 0, 0);
        set_in(0, c_nop, c_nop, 0, 0);
        i_ex_is_load = 2'b01;
        i_ex_rd[0]   = 5'd3;
        expect_at("lu1", 0, 2);
        set_in(0, c_nop, c_nop, 0, 0);
        expect_at("lu2", 2, 2);

        // Intra-group RAW.
        set_in(2, mk(4, 1, 2, 0, 0, 0), mk(5, 4, 1, 0, 0, 0), 0, 0);
        expect_at("raw0", 0, 0);
        set_in(0, c_nop, c_nop, 0, 0);
        expect_at("raw1", 1, 2);
        set_in(0, c_nop, c_nop, 0, 0);
        expect_at("raw2", 1, 1);

        // Two memory ops at the head.
        set_in(2, mk(2, 1, 0, 1, 1, 0), mk(3, 1, 0, 1, 1, 0), 0, 0);
        expect_at("mem0", 0, 0);
        set_in(0, c_nop, c_nop, 0, 0);
        expect_at("mem1", 1, 2);
        set_in(0, c_nop, c_nop, 0, 0);
        expect_at("mem2", 1, 1);

        // Branch in lane 1 waits for its delay slot.
        set_in(2, mk(1, 2, 3, 0, 0, 0), mk(0, 8, 9, 0, 0, 1), 0, 0);
        expect_at("br0", 0, 0);
        set_in(1, mk(10, 11, 12, 0, 0, 0), c_nop, 0, 0);
        expect_at("br1", 1, 2);
        set_in(0, c_nop, c_nop, 0, 0);
        expect_at("br2", 2, 2);
        set_in(0, c_nop, c_nop, 0, 0);
        expect_at("br3", 0, 0);

        // Fill under stall, then flush with a push presented.
        for (int r = 0; r < 4; r++) begin
            set_in(2, c_nop, c_nop, 1, 0);
            expect_at("fill", 0, 2 * r);
        end
        set_in(2, c_nop, c_nop, 1, 1);
        expect_at("full", 0, 8);
        chk("full_ready", 64'(o_fetch_ready), 64'd0);
        set_in(0, c_nop, c_nop, 1, 0);
        expect_at("flush0", 0, 0);
        chk("flush0_ready", 64'(o_fetch_ready), 64'd1);
        for (int r = 0; r < 3; r++) begin
            set_in(2, c_nop, c_nop, 1, 0);
            expect_at("refill", 0, 2 * r);
        end
        set_in(2, c_nop, c_nop, 1, 1);
        expect_at("flush1_pre", 0, 6);
        set_in(0, c_nop, c_nop, 0, 0);
        expect_at("flush1", 0, 0);

        // Randomized traffic with mid-run resets.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            nv = $urandom_range(0, 2);
            for (int l = 0; l < 2; l++) begin
                i_fetch_valid[l]                  = (l < nv);
                i_fetch_entry[l].pc               = 32'(pc_ctr);
                i_fetch_entry[l].instr            = $urandom();
                pc_ctr += 4;
                i_fetch_decoded[l].rd             = reg_addr_t'($urandom_range(0, 7));
                i_fetch_decoded[l].rs1            = reg_addr_t'($urandom_range(0, 7));
                i_fetch_decoded[l].rs2            = reg_addr_t'($urandom_range(0, 7));
                i_fetch_decoded[l].is_load        = ($urandom_range(0, 4) == 0);
                i_fetch_decoded[l].is_mem         = i_fetch_decoded[l].is_load || ($urandom_range(0, 9) == 0);
                i_fetch_decoded[l].is_controlflow = ($urandom_range(0, 6) == 0);
                i_ex_is_load[l]                   = ($urandom_range(0, 3) == 0);
                i_ex_rd[l]                        = reg_addr_t'($urandom_range(0, 7));
            end
            i_stall = ($urandom_range(0, 9) == 0);
            i_flush = ($urandom_range(0, 31) == 0);
            if (c == 1000 || c == 2000) begin
                #2 rst_n = 1'b0;
                #1 chk_reset("midrst");
                @(posedge clk);
                #1 rst_n = 1'b1;
            end
        end

        @(posedge clk);
        #1;
        i_fetch_valid = '0;
        i_flush       = 1'b0;
        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
